// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier share controller.
package dtc_pkg;

   localparam int FEAT_W_DEF = 8;
   localparam int CLS_W_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      HOLD = 2'd2
   } dtc_state_e;

endpackage

// File: rtl/dtc_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 with wrap.
module dtc_rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  last_grant,
   input  logic             enable,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any
);

   int              idx;
   logic [ID_W-1:0] idx_v;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      idx_v     = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_v = ID_W'(idx);
         if (enable && !any && req[idx_v]) begin
            any          = 1'b1;
            grant[idx_v] = 1'b1;
            grant_idx    = idx_v;
         end
      end
   end

endmodule

// File: rtl/dtc_share_ctrl.sv
// Time-shares one combinational classifier core between N_REQ requesters,
// returns class + requester ID over valid/ready and keeps per-class counters.
//
// state | meaning
// IDLE  | arbitrate; accept one feature vector from the granted requester
// EVAL  | registered feature drives the classifier core for a full cycle
// HOLD  | result presented on res_*; waits for res_ready
module dtc_share_ctrl
   import dtc_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int FEAT_W = FEAT_W_DEF,
   parameter  int CLS_W  = CLS_W_DEF,
   parameter  int CNT_W  = 16,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*FEAT_W-1:0] req_feat,
   output logic [N_REQ-1:0]        req_ready,
   output logic [FEAT_W-1:0]       cls_feat,
   input  logic [CLS_W-1:0]        cls_class,
   output logic                    res_valid,
   output logic [CLS_W-1:0]        res_class,
   output logic [ID_W-1:0]         res_id,
   input  logic                    res_ready,
   input  logic                    cnt_clear,
   input  logic [CLS_W-1:0]        cnt_sel,
   output logic [CNT_W-1:0]        cnt_value,
   output logic                    busy
);

   localparam int N_CLS = 2 ** CLS_W;

   dtc_state_e        state_q, state_d;
   logic [FEAT_W-1:0] feat_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [N_REQ-1:0]  arb_grant;
   logic [ID_W-1:0]   arb_idx;
   logic              arb_any;
   logic              accept;
   logic              complete;
   logic [CNT_W-1:0]  cnt_q [N_CLS];

   dtc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .enable     (state_q == IDLE),
      .grant      (arb_grant),
      .grant_idx  (arb_idx),
      .any        (arb_any)
   );

   assign req_ready = arb_grant;
   assign accept    = arb_any;
   assign complete  = (state_q == HOLD) && res_valid && res_ready;
   assign cls_feat  = feat_q;
   assign busy      = (state_q != IDLE);
   assign cnt_value = cnt_q[cnt_sel];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EVAL;
         EVAL:    state_d = HOLD;
         HOLD:    if (complete) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         feat_q       <= '0;
         id_q         <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         res_valid    <= 1'b0;
         res_class    <= '0;
         res_id       <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            feat_q       <= req_feat[int'(arb_idx)*FEAT_W +: FEAT_W];
            id_q         <= arb_idx;
            last_grant_q <= arb_idx;
         end
         if (state_q == EVAL) begin
            res_class <= cls_class;
            res_id    <= id_q;
            res_valid <= 1'b1;
         end else if (complete) begin
            res_valid <= 1'b0;
         end
      end
   end

   // Clear has priority over a same-cycle increment, so that result is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < N_CLS; c++) cnt_q[c] <= '0;
      end else if (cnt_clear) begin
         for (int c = 0; c < N_CLS; c++) cnt_q[c] <= '0;
      end else if (complete && (cnt_q[res_class] != '1)) begin
         cnt_q[res_class] <= cnt_q[res_class] + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_dtc_share_ctrl.sv
// Directed bench for dtc_share_ctrl: per-cycle vector table plus hand sequences
// for wrap-around, counter saturation/clear and asynchronous reset.
module tb_dtc_share_ctrl;

   localparam int N_REQ  = 4;
   localparam int FEAT_W = 8;
   localparam int CLS_W  = 2;
   localparam int CNT_W  = 3;
   localparam int ID_W   = 2;

   logic                    clk;
   logic                    rst_n;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*FEAT_W-1:0] req_feat;
   logic [N_REQ-1:0]        req_ready;
   logic [FEAT_W-1:0]       cls_feat;
   logic [CLS_W-1:0]        cls_class;
   logic                    res_valid;
   logic [CLS_W-1:0]        res_class;
   logic [ID_W-1:0]         res_id;
   logic                    res_ready;
   logic                    cnt_clear;
   logic [CLS_W-1:0]        cnt_sel;
   logic [CNT_W-1:0]        cnt_value;
   logic                    busy;

   int n_tests = 0;
   int n_fail  = 0;

   dtc_share_ctrl #(
      .N_REQ(N_REQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_feat  (req_feat),
      .req_ready (req_ready),
      .cls_feat  (cls_feat),
      .cls_class (cls_class),
      .res_valid (res_valid),
      .res_class (res_class),
      .res_id    (res_id),
      .res_ready (res_ready),
      .cnt_clear (cnt_clear),
      .cnt_sel   (cnt_sel),
      .cnt_value (cnt_value),
      .busy      (busy)
   );

   // classifier core model
   assign cls_class = cls_feat[1:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]  rv;
      logic [31:0] feat;
      logic        rr;
      logic        clr;
      logic [1:0]  sel;
      logic [3:0]  e_ready;
      logic        e_valid;
      logic [1:0]  e_class;
      logic [1:0]  e_id;
      logic        e_busy;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] rv, input logic [31:0] feat, input logic rr,
                      input logic [1:0] sel, input logic [3:0] e_ready, input logic e_valid,
                      input logic [1:0] e_class, input logic [1:0] e_id, input logic e_busy,
                      input logic [2:0] e_cnt);
      vec_t v;
      v.rv = rv; v.feat = feat; v.rr = rr; v.clr = 1'b0; v.sel = sel;
      v.e_ready = e_ready; v.e_valid = e_valid; v.e_class = e_class;
      v.e_id = e_id; v.e_busy = e_busy; v.e_cnt = e_cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete transaction from IDLE; returns to IDLE at a falling edge.
   task automatic run_txn(input int tag, input logic [3:0] rv, input logic [31:0] feat,
                          input logic clr, input logic [3:0] e_ready,
                          input logic [1:0] e_class, input logic [1:0] e_id);
      req_valid = rv;
      req_feat  = feat;
      res_ready = 1'b0;
      #1 chk("txn_ready", tag, 32'(req_ready), 32'(e_ready));
      cyc();
      req_valid = '0;
      #1 chk("txn_eval_busy", tag, 32'(busy), 32'd1);
      cyc();
      #1 chk("txn_valid", tag, 32'(res_valid), 32'd1);
      chk("txn_class", tag, 32'(res_class), 32'(e_class));
      chk("txn_id", tag, 32'(res_id), 32'(e_id));
      res_ready = 1'b1;
      cnt_clear = clr;
      cyc();
      res_ready = 1'b0;
      cnt_clear = 1'b0;
      #1 chk("txn_done", tag, 32'(res_valid), 32'd0);
   endtask

   localparam logic [31:0] FAIR = 32'h0302_0100;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_feat = '0; res_ready = 1'b0;
      cnt_clear = 1'b0; cnt_sel = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      //   rv       feat          rr  sel  ready    vld cls id busy cnt
      add(4'b0000, 32'h0,        0, 0, 4'b0000, 0, 0, 0, 0, 0); // reset state
      add(4'b1111, FAIR,         1, 0, 4'b0001, 0, 0, 0, 0, 0);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 0, 0, 0, 1, 0);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 1, 0, 0, 1, 0);
      add(4'b1111, FAIR,         1, 0, 4'b0010, 0, 0, 0, 0, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 0, 0, 0, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 1, 1, 1, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0100, 0, 1, 1, 0, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 0, 1, 1, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 1, 2, 2, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b1000, 0, 2, 2, 0, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 0, 2, 2, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 1, 3, 3, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0001, 0, 3, 3, 0, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 0, 3, 3, 1, 1);
      add(4'b1111, FAIR,         1, 0, 4'b0000, 1, 0, 0, 1, 1);
      add(4'b0000, FAIR,         1, 0, 4'b0000, 0, 0, 0, 0, 2);
      // single request from requester 1, feature A7 -> class 3
      add(4'b0010, 32'h0000_A700, 1, 3, 4'b0010, 0, 0, 0, 0, 1);
      add(4'b0000, 32'h0000_A700, 1, 3, 4'b0000, 0, 0, 0, 1, 1);
      add(4'b0000, 32'h0000_A700, 1, 3, 4'b0000, 1, 3, 1, 1, 1);
      add(4'b0000, 32'h0000_A700, 1, 3, 4'b0000, 0, 3, 1, 0, 2);
      // backpressure: five HOLD cycles without res_ready
      add(4'b0001, 32'h0000_0002, 0, 2, 4'b0001, 0, 3, 1, 0, 1);
      add(4'b1111, 32'h0000_0002, 0, 2, 4'b0000, 0, 3, 1, 1, 1);
      for (int i = 0; i < 5; i++)
         add(4'b1111, 32'h0000_0002, 0, 2, 4'b0000, 1, 2, 0, 1, 1);
      add(4'b0000, 32'h0000_0002, 1, 2, 4'b0000, 1, 2, 0, 1, 1);
      add(4'b0000, 32'h0000_0002, 1, 2, 4'b0000, 0, 2, 0, 0, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         req_valid = tbl[i].rv;
         req_feat  = tbl[i].feat;
         res_ready = tbl[i].rr;
         cnt_clear = tbl[i].clr;
         cnt_sel   = tbl[i].sel;
         #1;
         chk("req_ready", i, 32'(req_ready), 32'(tbl[i].e_ready));
         chk("res_valid", i, 32'(res_valid), 32'(tbl[i].e_valid));
         chk("res_class", i, 32'(res_class), 32'(tbl[i].e_class));
         chk("res_id",    i, 32'(res_id),    32'(tbl[i].e_id));
         chk("busy",      i, 32'(busy),      32'(tbl[i].e_busy));
         chk("cnt_value", i, 32'(cnt_value), 32'(tbl[i].e_cnt));
         cyc();
      end
      req_valid = '0;
      res_ready = 1'b0;

      // wrap-around: grant 3, then 2, then {0,2} valid -> 0
      run_txn(100, 4'b1000, 32'h0100_0000, 1'b0, 4'b1000, 2'd1, 2'd3);
      run_txn(101, 4'b0100, 32'h0003_0000, 1'b0, 4'b0100, 2'd3, 2'd2);
      run_txn(102, 4'b0101, 32'h0003_0000, 1'b0, 4'b0001, 2'd0, 2'd0);

      // clear, then saturate class 2 at 7
      cnt_clear = 1'b1;
      cyc();
      cnt_clear = 1'b0;
      cnt_sel   = 2'd2;
      #1 chk("clear_cnt2", 0, 32'(cnt_value), 32'd0);
      cnt_sel = 2'd0;
      #1 chk("clear_cnt0", 0, 32'(cnt_value), 32'd0);
      cnt_sel = 2'd2;
      for (int i = 0; i < 9; i++) begin
         run_txn(200 + i, 4'b0010, 32'h0000_0200, 1'b0, 4'b0010, 2'd2, 2'd1);
         if (i == 6) chk("sat_at7", i, 32'(cnt_value), 32'd7);
      end
      chk("sat_hold", 9, 32'(cnt_value), 32'd7);
      run_txn(300, 4'b0010, 32'h0000_0200, 1'b1, 4'b0010, 2'd2, 2'd1);
      chk("clear_wins", 0, 32'(cnt_value), 32'd0);
      run_txn(301, 4'b0010, 32'h0000_0200, 1'b0, 4'b0010, 2'd2, 2'd1);
      chk("count_after_clear", 0, 32'(cnt_value), 32'd1);

      // asynchronous reset while in EVAL
      req_valid = 4'b0001;
      req_feat  = 32'h0000_0001;
      #1 chk("rst_pre_ready", 0, 32'(req_ready), 32'b0001);
      cyc();
      req_valid = '0;
      #1 chk("rst_pre_busy", 0, 32'(busy), 32'd1);
      chk("rst_pre_feat", 0, 32'(cls_feat), 32'h01);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 0, 32'(res_valid), 32'd0);
      chk("rst_ready", 0, 32'(req_ready), 32'd0);
      chk("rst_busy",  0, 32'(busy),      32'd0);
      chk("rst_feat",  0, 32'(cls_feat),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 4'b1111;
      #1 chk("rst_first_grant", 0, 32'(req_ready), 32'b0001);
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         #1 chk("rst_cnt", s, 32'(cnt_value), 32'd0);
      end
      req_valid = '0;
      cyc();
      #1 chk("rst_idle_after", 0, 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
